// File: rtl/vga_pkg.sv
// Shared constants for the VGA 640x480@60 Hz timing generator:
// video timing, colour byte fields and 160x120 frame-buffer geometry.
package vga_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_H_TOT =
        VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOT =
        VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int CNT_W = 10;

    localparam int FG_MSB = 15;
    localparam int FG_LSB = 8;
    localparam int BG_MSB = 7;
    localparam int BG_LSB = 0;

    localparam int FB_COLS    = 160;
    localparam int FB_ROWS    = 120;
    localparam int FB_ADDRH_W = 8;
    localparam int FB_ADDRV_W = 7;

    // True when lo <= x < hi.
    function automatic logic in_win(
        input logic [CNT_W-1:0] x,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Enable-chained modulo counter: counts 0..MAX while en is high.
// Ports: CLK, Reset (async, active-high), en, count, tc (count==MAX && en).
module mod_counter #(
    parameter int W   = 4,
    parameter int MAX = 3
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MAX);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Combinational so the next counter in the chain advances on
    // the same edge as this one wraps.
    assign tc = en && (count == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing and pixel generator: pixel divider, h/v counters, 2-stage
// pixel pipeline. Ports: Reset, CLK, VGA_DATA, CONFIG_COLOURS in;
// ADDRH, ADDRV, VGA_HS, VGA_VS, VGA_COLOUR, FRAME_START out.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = VGA_H_VIS,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_VIS   = VGA_V_VIS,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input  logic                  Reset,
    input  logic                  CLK,
    input  logic                  VGA_DATA,
    input  logic [15:0]           CONFIG_COLOURS,
    output logic [FB_ADDRH_W-1:0] ADDRH,
    output logic [FB_ADDRV_W-1:0] ADDRV,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic [7:0]            VGA_COLOUR,
    output logic                  FRAME_START
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_unused;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             tick;
    logic             line_end;
    logic             frame_end;

    mod_counter #(.W(DIV_W), .MAX(CLK_DIV - 1)) u_div (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (1'b1),
        .count (div_unused),
        .tc    (tick)
    );

    mod_counter #(.W(CNT_W), .MAX(H_TOT - 1)) u_hcnt (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (tick),
        .count (hcount),
        .tc    (line_end)
    );

    mod_counter #(.W(CNT_W), .MAX(V_TOT - 1)) u_vcnt (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (line_end),
        .count (vcount),
        .tc    (frame_end)
    );

    // Stage 0: decode from the counters.
    logic act;
    logic hs0;
    logic vs0;

    assign act = (hcount < CNT_W'(H_VIS)) && (vcount < CNT_W'(V_VIS));
    assign hs0 = !in_win(hcount,
                         CNT_W'(H_VIS + H_FP),
                         CNT_W'(H_VIS + H_FP + H_SYNC));
    assign vs0 = !in_win(vcount,
                         CNT_W'(V_VIS + V_FP),
                         CNT_W'(V_VIS + V_FP + V_SYNC));

    // Stage 1: frame-buffer address plus delayed sync/active.
    logic hs1;
    logic vs1;
    logic act1;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ADDRH <= '0;
            ADDRV <= '0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            act1  <= 1'b0;
        end else if (tick) begin
            ADDRH <= act ? hcount[9:2] : '0;
            ADDRV <= act ? vcount[8:2] : '0;
            hs1   <= hs0;
            vs1   <= vs0;
            act1  <= act;
        end
    end

    // Stage 2: pixel data returned for the stage-1 address.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            VGA_HS     <= 1'b1;
            VGA_VS     <= 1'b1;
            VGA_COLOUR <= 8'h00;
        end else if (tick) begin
            VGA_HS <= hs1;
            VGA_VS <= vs1;
            if (!act1) begin
                VGA_COLOUR <= 8'h00;
            end else if (VGA_DATA) begin
                VGA_COLOUR <= CONFIG_COLOURS[FG_MSB:FG_LSB];
            end else begin
                VGA_COLOUR <= CONFIG_COLOURS[BG_MSB:BG_LSB];
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= frame_end;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen, reduced timing so several
// frames fit in a short run; random frame buffer and colour changes.
module tb_vga_timing_gen;

    localparam int D   = 3;
    localparam int HV  = 40;
    localparam int HF  = 4;
    localparam int HSW = 8;
    localparam int HB  = 6;
    localparam int VV  = 24;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int FT  = HT * VT;

    logic        Reset;
    logic        CLK;
    logic        VGA_DATA;
    logic [15:0] CONFIG_COLOURS;
    logic [7:0]  ADDRH;
    logic [6:0]  ADDRV;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [7:0]  VGA_COLOUR;
    logic        FRAME_START;

    vga_timing_gen #(
        .CLK_DIV (D),
        .H_VIS   (HV),
        .H_FP    (HF),
        .H_SYNC  (HSW),
        .H_BP    (HB),
        .V_VIS   (VV),
        .V_FP    (VF),
        .V_SYNC  (VSW),
        .V_BP    (VB)
    ) dut (
        .Reset          (Reset),
        .CLK            (CLK),
        .VGA_DATA       (VGA_DATA),
        .CONFIG_COLOURS (CONFIG_COLOURS),
        .ADDRH          (ADDRH),
        .ADDRV          (ADDRV),
        .VGA_HS         (VGA_HS),
        .VGA_VS         (VGA_VS),
        .VGA_COLOUR     (VGA_COLOUR),
        .FRAME_START    (FRAME_START)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic fb [0:127][0:255];

    int vectors;
    int errors;
    int n;

    logic       e_hs;
    logic       e_vs;
    logic       e_fs;
    logic [7:0] e_col;
    logic [7:0] e_ah;
    logic [6:0] e_av;
    logic [7:0] ah_prev;
    logic [6:0] av_prev;

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            if (errors <= 20)
                $error("FAIL %s n=%0d got %0h want %0h", tag, n, obs, exp);
        end
    endtask

    // Position q ticks after release, as (column, line).
    task automatic posn(input int q, output int h, output int v);
        int p;
        p = q % FT;
        h = p % HT;
        v = p / HT;
    endtask

    task automatic model_reset();
        n     = 0;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        e_fs  = 1'b0;
        e_col = 8'h00;
        e_ah  = 8'h00;
        e_av  = 7'h00;
    endtask

    // After tick k the address shows position k-1 and the pixel/sync
    // outputs show position k-2.
    task automatic model_tick(input logic [15:0] cfg);
        int  k;
        int  h;
        int  v;
        logic a;
        k = n / D;
        if (k - 2 >= 0) begin
            posn(k - 2, h, v);
            a     = (h < HV) && (v < VV);
            e_hs  = !((h >= HV + HF) && (h < HV + HF + HSW));
            e_vs  = !((v >= VV + VF) && (v < VV + VF + VSW));
            e_col = !a ? 8'h00 : (fb[v / 4][h / 4] ? cfg[15:8] : cfg[7:0]);
        end
        if (k - 1 >= 0) begin
            posn(k - 1, h, v);
            a    = (h < HV) && (v < VV);
            e_ah = a ? 8'(h / 4) : 8'h00;
            e_av = a ? 7'(v / 4) : 7'h00;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, "_hs"},  16'(VGA_HS),      16'(e_hs));
        chk({ph, "_vs"},  16'(VGA_VS),      16'(e_vs));
        chk({ph, "_col"}, 16'(VGA_COLOUR),  16'(e_col));
        chk({ph, "_ah"},  16'(ADDRH),       16'(e_ah));
        chk({ph, "_av"},  16'(ADDRV),       16'(e_av));
        chk({ph, "_fs"},  16'(FRAME_START), 16'(e_fs));
    endtask

    // One CLK: model update, memory read response, random colour change.
    task automatic step(input string ph);
        logic [15:0] cfg_e;
        cfg_e = CONFIG_COLOURS;
        @(posedge CLK);
        if (!Reset) n++;
        #1;
        e_fs = !Reset && n > 0 && (n % D == 0) && ((n / D) % FT == 0);
        if (!Reset && n % D == 0) model_tick(cfg_e);
        VGA_DATA = fb[av_prev][ah_prev];
        ah_prev  = ADDRH;
        av_prev  = ADDRV;
        check_all(ph);
        if ($urandom_range(0, 999) < 3) begin
            case ($urandom_range(0, 2))
                0:       CONFIG_COLOURS = 16'hE003;
                1:       CONFIG_COLOURS = 16'h1C03;
                default: CONFIG_COLOURS = 16'($urandom);
            endcase
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 256; c++)
                fb[r][c] = 1'($urandom);
        fb[5][10]      = 1'b1;
        Reset          = 1'b1;
        VGA_DATA       = 1'b0;
        CONFIG_COLOURS = 16'hE003;
        ah_prev        = '0;
        av_prev        = '0;
        model_reset();

        #2;
        check_all("por");
        for (int i = 0; i < 4; i++) step("inrst");
        Reset = 1'b0;

        // Run into the second frame, stopping inside line 10, column 20.
        while (n != (FT + 10 * HT + 20) * D + 1) step("run1");

        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all("async");

        for (int i = 0; i < 4; i++) step("hold");
        Reset = 1'b0;

        for (int i = 0; i < FT * D + HT * D * 5; i++) step("run2");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
